// File: rtl/palette_arbiter_pkg.sv
// Shared LCD palette definitions: write-buffer FSM states and palette geometry.
package palette_arbiter_pkg;

  localparam int PAL_DEPTH = 256;
  localparam int PAL_W     = 16;
  localparam int PAL_AW    = $clog2(PAL_DEPTH);

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/palette_arbiter.sv
// Single-port palette RAM arbiter: pixel lookups vs. register-bus access through a
// 1-entry write buffer, with starvation bound and buffer-to-read forwarding.
module palette_arbiter
  import palette_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              pix_req,
  input  logic [PAL_AW-1:0] pix_addr,
  output logic              pix_gnt,
  output logic [PAL_W-1:0]  pix_rdata,
  output logic              pix_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  logic [PAL_W-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic [PAL_W-1:0]  cpu_rdata,
  output logic              cpu_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [PAL_AW-1:0] ram_addr,
  output logic [PAL_W-1:0]  ram_wdata,
  input  logic [PAL_W-1:0]  ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_state_e         state, state_nx;
  logic              wb_valid;
  logic [PAL_AW-1:0] wb_addr;
  logic [PAL_W-1:0]  wb_data;
  logic [SW-1:0]     starve_cnt, starve_nx;

  logic cpu_rd, cpu_wr, rd_hit, rd_ram, cpu_work, starved;
  logic pix_win, drain, rd_win, wr_acc, pix_fwd;

  logic             pix_vld_q, pix_fwd_q, cpu_vld_q, cpu_fwd_q;
  logic [PAL_W-1:0] pix_fwd_data_q, cpu_fwd_data_q, pix_hold_q, cpu_hold_q;

  assign wb_valid = (state == WB_FULL);
  assign cpu_rd   = cpu_req & ~cpu_we;
  assign cpu_wr   = cpu_req & cpu_we;
  assign rd_hit   = cpu_rd & wb_valid & (cpu_addr == wb_addr);
  assign rd_ram   = cpu_rd & ~rd_hit;
  assign cpu_work = wb_valid | rd_ram;
  assign starved  = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    pix_win   = 1'b0;
    drain     = 1'b0;
    rd_win    = 1'b0;
    wr_acc    = 1'b0;
    pix_fwd   = 1'b0;
    pix_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = pix_addr;
    ram_wdata = wb_data;
    state_nx  = state;
    starve_nx = starve_cnt;
    if (!HRESET) begin
      // Pixel side owns the RAM unless pending CPU work has hit the starvation bound.
      pix_win = pix_req & ~(starved & cpu_work);
      drain   = wb_valid & ~pix_win;
      rd_win  = rd_ram & ~pix_win & ~wb_valid;
      wr_acc  = cpu_wr & (~wb_valid | drain);
      pix_fwd = pix_win & wb_valid & (pix_addr == wb_addr);
      pix_gnt = pix_win;
      cpu_gnt = wr_acc | rd_hit | rd_win;
      ram_en  = pix_win | drain | rd_win;
      ram_we  = drain;
      if (drain)       ram_addr = wb_addr;
      else if (rd_win) ram_addr = cpu_addr;
      if (wr_acc)     state_nx = WB_FULL;
      else if (drain) state_nx = WB_EMPTY;
      if (drain || rd_win || !cpu_work) starve_nx = '0;
      else if (!starved)                starve_nx = starve_cnt + 1'b1;
    end
  end

  // Read data is live from RAM/forward register on the strobe, held afterwards.
  assign pix_rvalid = pix_vld_q;
  assign cpu_rvalid = cpu_vld_q;
  assign pix_rdata  = pix_vld_q ? (pix_fwd_q ? pix_fwd_data_q : ram_rdata) : pix_hold_q;
  assign cpu_rdata  = cpu_vld_q ? (cpu_fwd_q ? cpu_fwd_data_q : ram_rdata) : cpu_hold_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state          <= WB_EMPTY;
      starve_cnt     <= '0;
      wb_addr        <= '0;
      wb_data        <= '0;
      pix_vld_q      <= 1'b0;
      pix_fwd_q      <= 1'b0;
      pix_fwd_data_q <= '0;
      pix_hold_q     <= '0;
      cpu_vld_q      <= 1'b0;
      cpu_fwd_q      <= 1'b0;
      cpu_fwd_data_q <= '0;
      cpu_hold_q     <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (wr_acc) begin
        wb_addr <= cpu_addr;
        wb_data <= cpu_wdata;
      end
      pix_vld_q <= pix_win;
      pix_fwd_q <= pix_fwd;
      if (pix_fwd)   pix_fwd_data_q <= wb_data;
      if (pix_vld_q) pix_hold_q     <= pix_rdata;
      cpu_vld_q <= rd_win | rd_hit;
      cpu_fwd_q <= rd_hit;
      if (rd_hit)    cpu_fwd_data_q <= wb_data;
      if (cpu_vld_q) cpu_hold_q     <= cpu_rdata;
    end
  end

endmodule
